// File: rtl/mac_chain_ctrl_if.sv
// Operand and result streams of the MAC chain sequencer.
// master = operand buffers / result consumer side, slave = sequencer side.
interface mac_chain_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int N_PE       = 2
);
    localparam int IDX_W = $clog2(N_PE) + 1;

    logic                  a_valid;
    logic                  a_ready;
    logic [DATA_WIDTH-1:0] a_data;
    logic                  b_valid;
    logic                  b_ready;
    logic [DATA_WIDTH-1:0] b_data;
    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] res_data;
    logic [IDX_W-1:0]      res_idx;

    modport master (
        output a_valid, a_data, b_valid, b_data, res_ready,
        input  a_ready, b_ready, res_valid, res_data, res_idx
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data, res_ready,
        output a_ready, b_ready, res_valid, res_data, res_idx
    );
endinterface

// File: rtl/mac_chain_ctrl.sv
// Sequencer for a linear chain of MAC PEs: clears the accumulators, streams
// k_len operand pairs into PE0 (zero bubbles on stalls), waits out the chain
// latency, snapshots every PE result and returns them one per handshake.
module mac_chain_ctrl #(
    parameter int  DATA_WIDTH = 32,
    parameter int  N_PE       = 2,
    parameter int  MAC_LAT    = 1,
    parameter int  K_MAX      = 255,
    localparam int CNT_W      = $clog2(K_MAX + 1),
    localparam int IDX_W      = $clog2(N_PE) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [CNT_W-1:0]           k_len,
    output logic                       busy,
    output logic                       done,
    output logic                       mac_clr,
    output logic [DATA_WIDTH-1:0]      A_in,
    output logic [DATA_WIDTH-1:0]      B_in,
    input  logic [N_PE*DATA_WIDTH-1:0] c_in,
    mac_chain_ctrl_if.slave            bus
);
    // DRAIN runs for DRN_LAST+1 cycles so the last operand reaches the tail PE
    localparam int DRN_LAST = N_PE * MAC_LAT;
    localparam int DRN_W    = $clog2(DRN_LAST + 1);
    // one extra bit so the saturation compare is meaningful for any K_MAX
    localparam logic [CNT_W:0] K_MAX_X = (CNT_W + 1)'(K_MAX);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_OUT} state_t;

    state_t                            state, state_nxt;
    logic   [CNT_W-1:0]                k_q, cnt, k_sat;
    logic   [DRN_W-1:0]                dcnt;
    logic   [IDX_W-1:0]                res_idx_q;
    logic   [N_PE-1:0][DATA_WIDTH-1:0] res_q;
    logic   [DATA_WIDTH-1:0]           res_data_c;
    logic                              res_valid_q;
    logic                              fire, last_fire, drain_end, res_hs, last_hs, zero_job;

    assign k_sat     = ({1'b0, k_len} > K_MAX_X) ? K_MAX_X[CNT_W-1:0] : k_len;
    // both streams are consumed together or not at all
    assign fire      = (state == S_FEED) & bus.a_valid & bus.b_valid;
    assign last_fire = fire & (cnt == k_q - CNT_W'(1));
    assign drain_end = (state == S_DRAIN) & (dcnt == DRN_W'(DRN_LAST));
    assign res_hs    = (state == S_OUT) & res_valid_q & bus.res_ready;
    assign last_hs   = res_hs & (res_idx_q == IDX_W'(N_PE - 1));
    assign zero_job  = (state == S_IDLE) & start & (k_len == '0);

    assign bus.a_ready   = fire;
    assign bus.b_ready   = fire;
    assign bus.res_valid = res_valid_q;
    assign bus.res_idx   = res_idx_q;
    assign bus.res_data  = res_data_c;

    // State register; reset aborts any job in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && k_len != '0) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_FEED;
            S_FEED:  if (last_fire) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_end) state_nxt = S_OUT;
            S_OUT:   if (last_hs) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered status outputs, derived from the upcoming state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy        <= 1'b0;
            mac_clr     <= 1'b0;
            res_valid_q <= 1'b0;
            done        <= 1'b0;
        end else begin
            busy        <= (state_nxt != S_IDLE);
            mac_clr     <= (state_nxt == S_CLEAR);
            res_valid_q <= (state_nxt == S_OUT);
            done        <= zero_job | last_hs;
        end
    end

    // Job length, pair counter and drain timer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q  <= '0;
            cnt  <= '0;
            dcnt <= '0;
        end else begin
            if (state == S_IDLE && start) k_q <= k_sat;
            if (state == S_CLEAR)         cnt <= '0;
            else if (fire)                cnt <= cnt + CNT_W'(1);
            if (state == S_DRAIN && state_nxt == S_DRAIN) dcnt <= dcnt + DRN_W'(1);
            else                                          dcnt <= '0;
        end
    end

    // Operand registers to PE0: a bubble (no fire) pushes a zero product
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            A_in <= '0;
            B_in <= '0;
        end else begin
            A_in <= fire ? bus.a_data : '0;
            B_in <= fire ? bus.b_data : '0;
        end
    end

    // Snapshot of every PE accumulator, taken on the edge that ends DRAIN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q <= '0;
        end else if (drain_end) begin
            for (int i = 0; i < N_PE; i++) res_q[i] <= c_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Result index walks the snapshot one handshake at a time
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                      res_idx_q <= '0;
        else if (drain_end || last_hs) res_idx_q <= '0;
        else if (res_hs)               res_idx_q <= res_idx_q + IDX_W'(1);
    end

    // Result mux; stable while the consumer stalls since its inputs are registers
    always_comb begin
        res_data_c = '0;
        for (int i = 0; i < N_PE; i++)
            if (res_idx_q == IDX_W'(i)) res_data_c = res_q[i];
    end
endmodule

// File: tb/tb_mac_chain_ctrl.sv
// Randomized scoreboard bench for mac_chain_ctrl with a behavioural PE chain.
module tb_mac_chain_ctrl;
    localparam int DW   = 32;
    localparam int NPE  = 2;
    localparam int LAT  = 1;
    localparam int KMAX = 255;
    localparam int CW   = $clog2(KMAX + 1);
    localparam int L    = NPE * LAT;

    typedef struct {
        logic [DW-1:0] data;
        int            idx;
        bit            last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [CW-1:0]     k_len = '0;
    logic              busy, done, mac_clr;
    logic [DW-1:0]     A_in, B_in;
    logic [NPE*DW-1:0] c_in;

    mac_chain_ctrl_if #(.DATA_WIDTH(DW), .N_PE(NPE)) bus ();

    mac_chain_ctrl #(.DATA_WIDTH(DW), .N_PE(NPE), .MAC_LAT(LAT), .K_MAX(KMAX)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .done(done),
        .mac_clr(mac_clr), .A_in(A_in), .B_in(B_in), .c_in(c_in), .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- PE chain model ----------------
    logic [DW-1:0] da [0:L];
    logic [DW-1:0] db [0:L];
    logic [DW-1:0] acc [0:NPE-1];

    initial begin
        for (int j = 0; j <= L; j++) begin da[j] = '0; db[j] = '0; end
        for (int i = 0; i < NPE; i++) acc[i] = '0;
    end

    always @(posedge clk) begin
        logic [DW-1:0] ai, bi;
        for (int j = 1; j <= L; j++) begin
            da[j] <= (j == 1) ? A_in : da[j-1];
            db[j] <= (j == 1) ? B_in : db[j-1];
        end
        for (int i = 0; i < NPE; i++) begin
            ai = (i == 0) ? A_in : da[i*LAT];
            bi = (i == 0) ? B_in : db[i*LAT];
            acc[i] <= mac_clr ? '0 : acc[i] + ai * bi;
        end
    end

    always_comb begin
        c_in = '0;
        for (int i = 0; i < NPE; i++) c_in[i*DW +: DW] = acc[i];
    end

    // ---------------- scoreboard state ----------------
    int total = 0, bad = 0;
    logic [DW-1:0] qa[$], qb[$];
    exp_t expq[$];
    int a_pct = 0, b_pct = 0, rr_pct = 100;
    int b_stall_at = -1, b_stall_len = 0, bp_left = 0;
    int t0 = 0, job_k = 0, job_fires = 0, last_fire_cyc = -100, exp_rel = -1, done_due = -1;
    bit rv_seen = 0;
    bit fire_pend = 0, hs_pend = 0, prev_hold = 0, av = 0, bv = 0;
    logic [DW-1:0] fa, fb, hs_data, hold_data, exp_a = '0, exp_b = '0;
    logic [NPE:0]  hs_idx, hold_idx;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor + stream driver: consume last edge's events, check, drive, sample.
    always @(negedge clk) begin
        exp_t e;
        if (rst && fire_pend) begin
            void'(qa.pop_front());
            void'(qb.pop_front());
            job_fires++;
            if (job_fires == job_k) last_fire_cyc = cyc - 1;
        end
        exp_a = (rst && fire_pend) ? fa : '0;
        exp_b = (rst && fire_pend) ? fb : '0;
        if (rst && hs_pend) begin
            if (expq.size() == 0) begin
                check("extra_result", 1, 0);
            end else begin
                e = expq.pop_front();
                check("res_data", hs_data, e.data);
                check("res_idx", hs_idx, e.idx);
                if (e.last) done_due = cyc;
            end
        end

        check("A_in", A_in, exp_a);
        check("B_in", B_in, exp_b);
        check("done", done, cyc == done_due);
        if (cyc == done_due) check("busy_at_done", busy, 0);
        if (prev_hold) begin
            check("hold_valid", bus.res_valid, 1);
            check("hold_data", bus.res_data, hold_data);
            check("hold_idx", bus.res_idx, hold_idx);
        end
        if (bus.res_valid && !rv_seen && job_k > 0) begin
            rv_seen = 1;
            check("rv_after_last_fire", cyc, last_fire_cyc + L + 2);
            if (exp_rel >= 0) check("rv_rel", cyc - t0, exp_rel);
        end

        av = (qa.size() > 0) && ($urandom_range(99) >= a_pct);
        bv = (qb.size() > 0) && ($urandom_range(99) >= b_pct);
        if (job_fires == b_stall_at && b_stall_len > 0) begin
            bv = 0;
            b_stall_len--;
        end
        bus.a_valid = av;
        bus.b_valid = bv;
        bus.a_data  = av ? qa[0] : $urandom;
        bus.b_data  = bv ? qb[0] : $urandom;
        if (bp_left > 0 && bus.res_valid) begin
            bus.res_ready = 0;
            bp_left--;
        end else begin
            bus.res_ready = ($urandom_range(99) < rr_pct);
        end

        #1;
        check("ready_joint", bus.a_ready, bus.b_ready);
        if (!(av && bv) || !rst) check("ready_idle", bus.a_ready, 0);
        fire_pend = rst && bus.a_ready && av && bv;
        fa        = bus.a_data;
        fb        = bus.b_data;
        hs_pend   = rst && bus.res_valid && bus.res_ready;
        hs_data   = bus.res_data;
        hs_idx    = bus.res_idx;
        prev_hold = rst && bus.res_valid && !bus.res_ready;
        hold_data = bus.res_data;
        hold_idx  = bus.res_idx;
    end

    // ---------------- stimulus ----------------
    task automatic push_op(input logic [DW-1:0] a, input logic [DW-1:0] b);
        qa.push_back(a);
        qb.push_back(b);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_mac_clr"}, mac_clr, 0);
        check({tag, "_a_ready"}, bus.a_ready, 0);
        check({tag, "_b_ready"}, bus.b_ready, 0);
        check({tag, "_res_valid"}, bus.res_valid, 0);
        check({tag, "_A_in"}, A_in, 0);
        check({tag, "_B_in"}, B_in, 0);
        check({tag, "_res_data"}, bus.res_data, 0);
        check({tag, "_res_idx"}, bus.res_idx, 0);
    endtask

    // Called at negedge+2 of the cycle that becomes cycle 0; returns in cycle 1.
    task automatic issue_start(input int k, input int erv);
        logic [DW-1:0] dot;
        dot = '0;
        for (int i = 0; i < k; i++) dot += qa[i] * qb[i];
        t0 = cyc; job_k = k; job_fires = 0; last_fire_cyc = -100; rv_seen = 0; exp_rel = erv;
        if (k == 0) done_due = cyc + 1;
        else for (int i = 0; i < NPE; i++) expq.push_back('{dot, i, (i == NPE - 1)});
        start = 1;
        k_len = CW'(k);
        @(negedge clk); #2;
        start = 0;
        k_len = CW'($urandom);
        check("busy_c1", busy, k != 0);
        check("mac_clr_c1", mac_clr, k != 0);
    endtask

    task automatic wait_done(input int edone);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 3000) begin @(negedge clk); #2; n++; end
        if (done !== 1'b1) begin
            total++; bad++;
            $display("FAIL wait_done: no done pulse within %0d cycles", n);
        end else if (edone >= 0) begin
            check("done_rel", cyc - t0, edone);
        end
    endtask

    initial begin
        int k, n;
        bus.a_valid = 0; bus.b_valid = 0; bus.a_data = '0; bus.b_data = '0; bus.res_ready = 0;
        repeat (3) @(negedge clk);
        #2;
        check_reset_vals("reset");
        rst = 1;
        @(negedge clk); #2;

        // basic job
        push_op(1, 4); push_op(2, 5); push_op(3, 6);
        issue_start(3, 3 + L + 3);
        wait_done(3 + L + 3 + NPE);

        // two-cycle b stall after the first fire
        push_op(1, 4); push_op(2, 5); push_op(3, 6);
        b_stall_at = 1; b_stall_len = 2;
        issue_start(3, 3 + L + 3 + 2);
        wait_done(3 + L + 3 + 2 + NPE);
        b_stall_at = -1;

        // result backpressure: 5 cycles held low at the start of OUT
        push_op(1, 4); push_op(2, 5); push_op(3, 6);
        bp_left = 5;
        issue_start(3, 3 + L + 3);
        wait_done(3 + L + 3 + 5 + NPE);

        // zero-length job
        issue_start(0, -1);
        wait_done(1);
        @(negedge clk); #2;
        check("zero_busy_c2", busy, 0);
        check("zero_clr_c2", mac_clr, 0);

        // abort after two fires
        push_op(10, 1); push_op(20, 2); push_op(30, 3); push_op(40, 4);
        issue_start(4, -1);
        n = 0;
        while (job_fires < 2 && n < 50) begin @(negedge clk); #2; n++; end
        rst = 0;
        fire_pend = 0; hs_pend = 0; prev_hold = 0;
        expq.delete(); done_due = -1; job_k = 0;
        #1;
        check_reset_vals("abort");
        repeat (3) @(negedge clk);
        #2;
        check("abort_no_consume", qa.size(), 2);
        qa.delete(); qb.delete();
        rst = 1;
        push_op(7, 9);
        issue_start(1, 1 + L + 3);
        wait_done(1 + L + 3 + NPE);

        // start during DRAIN ignored, then back-to-back start in the done cycle
        push_op(1, 4); push_op(2, 5); push_op(3, 6);
        issue_start(3, 3 + L + 3);
        while (cyc - t0 < 3 + 3) begin @(negedge clk); #2; end
        check("drain_busy", busy, 1);
        start = 1; k_len = CW'(5);
        @(negedge clk); #2;
        start = 0;
        wait_done(3 + L + 3 + NPE);
        push_op(2, 5); push_op(3, 7);
        issue_start(2, 2 + L + 3);
        wait_done(2 + L + 3 + NPE);

        // randomized jobs with stalls on both sides
        rr_pct = 60;
        for (int j = 0; j < 16; j++) begin
            k = (j == 15) ? KMAX : $urandom_range(1, 12);
            for (int i = 0; i < k; i++) push_op($urandom, $urandom);
            a_pct = $urandom_range(0, 40);
            b_pct = $urandom_range(0, 40);
            issue_start(k, -1);
            wait_done(-1);
            if ($urandom_range(1) == 1) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                #2;
            end
        end

        repeat (4) @(negedge clk);
        #2;
        check("leftover_results", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mac_chain_ctrl.md
# mac_chain_ctrl

Sequencer for a linear chain of `N_PE` MAC processing elements, where each PE forwards A/B to the next and accumulates `C`. It accepts one dot-product job at a time (`start`, `k_len`) and clears the PE accumulators. It then streams `k_len` operand pairs from two valid/ready sources into the head of the chain, inserting zero bubbles on stalls. After waiting out the chain latency, it snapshots every PE's `C_out` and returns the results one per handshake. It sits between the operand buffers and the MAC chain.

## Interface
- `DATA_WIDTH`, 32: operand/result width.
- `N_PE`, 2: number of PEs in the chain; must be ≥1.
- `MAC_LAT`, 1: register stages per PE (A/B in→out).
- `K_MAX`, 255: maximum job length; `CNT_W = $clog2(K_MAX+1)`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low (asserted when 0).
- `start`  in  1  job request, sampled only in IDLE.
- `k_len`  in  CNT_W  operand pairs in the job, sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at job completion.
- `a_valid`, `b_valid`  in  1  operand stream valids.
- `a_data`, `b_data`  in  DATA_WIDTH  operand stream data.
- `a_ready`, `b_ready`  out  1  operand stream readies.
- `mac_clr`  out  1  synchronous accumulator clear to all PEs.
- `A_in`, `B_in`  out  DATA_WIDTH  registered operands to PE0.
- `c_in`  in  N_PE*DATA_WIDTH  concatenated PE `C_out`s; PE i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumer ready.
- `res_data`  out  DATA_WIDTH  current result.
- `res_idx`  out  $clog2(N_PE)+1  PE index of `res_data`.

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, OUT.
- **IDLE**
  - `start`=1 with `k_len`≠0 → CLEAR; latch `k_len`.
  - `start`=1 with `k_len`=0 → `done` pulse next cycle; stay IDLE.
  - `k_len` > `K_MAX` is saturated to `K_MAX`.
- **CLEAR** (exactly 1 cycle): `mac_clr`=1, `A_in`/`B_in`=0 → FEED; pair counter=0.
- **FEED**
  - Joint handshake: `a_ready` = `b_ready` = `a_valid` & `b_valid`. A fire consumes both streams together; no partial consumption.
  - On a fire edge: `A_in`←`a_data`, `B_in`←`b_data`, counter++.
  - On a non-fire edge: `A_in`/`B_in`←0, so the bubble contributes a 0 product.
  - After the `k_len`-th fire → DRAIN; `A_in`/`B_in`←0 from then on.
- **DRAIN**
  - Lasts exactly `N_PE*MAC_LAT+1` cycles, operands held at 0.
  - On the edge ending DRAIN, all `c_in` words are captured into internal result registers → OUT with `res_idx`=0.
- **OUT**
  - `res_valid`=1, `res_data` = captured word[`res_idx`].
  - On `res_valid` & `res_ready`, `res_idx`++.
  - After the handshake with `res_idx`=`N_PE`-1 → IDLE with `done`=1 for that next cycle.
  - `res_data` is stable while `res_ready`=0.
- `start` is ignored while `busy`=1.
- `a_ready`/`b_ready` are 0 outside FEED.
- Captured results are unaffected by later `c_in` changes.

## Timing
- Reset values (asynchronous, while `rst`=0):
  - state=IDLE.
  - `busy`, `done`, `mac_clr`, `a_ready`, `b_ready`, `res_valid` = 0.
  - `A_in`, `B_in`, `res_data`, `res_idx`, counters = 0.
- Reset mid-job aborts immediately: no `done`, results discarded, operand streams not consumed after reset.
- `start` sampled in cycle 0:
  - `busy`=1 and `mac_clr`=1 in cycle 1.
  - First possible fire in cycle 2.
- No stalls: first `res_valid` in cycle `k_len + N_PE*MAC_LAT + 3`.
- Each FEED stall cycle adds exactly 1 cycle.
- `done` is a single-cycle pulse in the cycle after the last result handshake, with `busy`=0 in that cycle. `start` is accepted in that same cycle.
- All outputs are registered except `a_ready`, `b_ready`, and `res_data`. `res_data` is a mux of registers driven by `res_idx`.
- Counter width is CNT_W; no wrap is possible because `k_len` ≤ `K_MAX`.

## Test plan
- **Basic job.** Setup: `N_PE`=2, `MAC_LAT`=1; bench models PEs. Stimulus: `k_len`=3, A={1,2,3}, B={4,5,6}, no stalls. Required: `res_valid` in cycle 8; results 32 (idx 0) then 32 (idx 1); `done` one cycle after the second handshake.
- **Stalls.** Same data, `b_valid` low for 2 cycles mid-stream. Required: `A_in`/`B_in`=0 during the stall, no consumption of the A stream, results still 32/32, `res_valid` delayed to cycle 10.
- **Backpressure.** `res_ready` held low 5 cycles in OUT. Required: `res_data` and `res_idx` stable, `done` delayed accordingly.
- **Zero length.** `start` with `k_len`=0. Required: `done` pulse in cycle 1, `busy` never 1, `mac_clr` never 1.
- **Abort.** `rst` low during FEED after 2 fires. Required: all outputs at reset values immediately, no `done`; a following job with `k_len`=1, A=7, B=9 returns 63/63.
- **Start while busy.** `start` pulsed during DRAIN with a different `k_len`. Required: ignored, current job unchanged; back-to-back `start` in the `done` cycle is accepted.
